// File: rtl/fetch_pc_control_if.sv
// Fetch sequencer control bundle: debug-unit run/step control, redirect/stall
// inputs from later stages, and the fetch address/status outputs.
interface fetch_pc_control_if #(
    parameter int LEN = 32
);
    logic           i_start;
    logic           i_mode;
    logic           i_step;
    logic           i_stall;
    logic           i_branch_taken;
    logic [LEN-1:0] i_branch_target;
    logic           i_jump;
    logic [LEN-1:0] i_jump_target;
    logic           i_halt_instr;
    logic [LEN-1:0] o_pc;
    logic [LEN-1:0] o_pc_plus4;
    logic           o_valid;
    logic           o_halted;
    logic [31:0]    o_cycle_count;

    modport master (
        output i_start, i_mode, i_step, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_halt_instr,
        input  o_pc, o_pc_plus4, o_valid, o_halted, o_cycle_count
    );

    modport slave (
        input  i_start, i_mode, i_step, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_halt_instr,
        output o_pc, o_pc_plus4, o_valid, o_halted, o_cycle_count
    );
endinterface

// File: rtl/fetch_pc_control.sv
// PC register and fetch sequencer: selects branch/jump/stall/halt/sequential next
// PC on advance cycles, gated by debug-unit continuous-run or single-step control.
module fetch_pc_control #(
    parameter int LEN = 32,
    parameter int INC = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fetch_pc_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    localparam logic [LEN-1:0] ALIGN_MASK = ~LEN'(3);

    state_t         state_q, state_d;
    logic [LEN-1:0] pc_q, pc_d;
    logic           halted_q, halted_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           adv;

    assign adv = (state_q == RUN) || ((state_q == STEP) && bus.i_step);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE) begin
            if (bus.i_start) state_d = bus.i_mode ? STEP : RUN;
        end else if (adv) begin
            cnt_d = cnt_q + 32'd1;
            // Redirects flush the HALT; a stall defers it to the next advance.
            if (bus.i_branch_taken) begin
                pc_d = bus.i_branch_target & ALIGN_MASK;
            end else if (bus.i_jump) begin
                pc_d = bus.i_jump_target & ALIGN_MASK;
            end else if (bus.i_stall) begin
                pc_d = pc_q;
            end else if (bus.i_halt_instr) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + LEN'(INC);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_pc_plus4    = pc_q + LEN'(INC);
    assign bus.o_valid       = adv;
    assign bus.o_halted      = halted_q;
    assign bus.o_cycle_count = cnt_q;
endmodule

// File: tb/tb_fetch_pc_control.sv
// Directed and randomized checks of fetch_pc_control against a cycle-level
// behavioural model of the sequencing rules.
module tb_fetch_pc_control;
    logic i_clk = 1'b0;
    logic i_reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 i_clk = ~i_clk;

    fetch_pc_control_if #(.LEN(32)) bus ();

    fetch_pc_control #(.LEN(32), .INC(4)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    // Model: mode 0 idle, 1 running, 2 stepping, 3 halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic md, input logic sp, input logic stl,
                         input logic br, input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt, input logic h);
        bus.i_start = st; bus.i_mode = md; bus.i_step = sp; bus.i_stall = stl;
        bus.i_branch_taken = br; bus.i_branch_target = bt;
        bus.i_jump = jp; bus.i_jump_target = jt; bus.i_halt_instr = h;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Called shortly after a rising edge; pulses reset, checks it took effect
    // with no clock edge, releases it before the next edge.
    task automatic do_reset();
        i_reset = 1'b1;
        #1;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        chk("rst_pc", bus.o_pc, 32'h0);
        chk("rst_valid", {31'b0, bus.o_valid}, 32'h0);
        chk("rst_halted", {31'b0, bus.o_halted}, 32'h0);
        chk("rst_cnt", bus.o_cycle_count, 32'h0);
        #1;
        i_reset = 1'b0;
    endtask

    // One clock cycle with the currently driven inputs; checks all outputs
    // against the model, then applies the model's rules for the edge.
    task automatic cyc();
        bit adv;
        #1;
        adv = (m_mode == 1) || (m_mode == 2 && bus.i_step);
        chk("pc", bus.o_pc, m_pc);
        chk("pc_plus4", bus.o_pc_plus4, m_pc + 32'd4);
        chk("valid", {31'b0, bus.o_valid}, {31'b0, adv});
        chk("halted", {31'b0, bus.o_halted}, (m_mode == 3) ? 32'h1 : 32'h0);
        chk("cycle_count", bus.o_cycle_count, m_cnt);
        @(posedge i_clk);
        if (m_mode == 0) begin
            if (bus.i_start) m_mode = bus.i_mode ? 2 : 1;
        end else if (adv) begin
            m_cnt = m_cnt + 1;
            if (bus.i_branch_taken)   m_pc = {bus.i_branch_target[31:2], 2'b00};
            else if (bus.i_jump)      m_pc = {bus.i_jump_target[31:2], 2'b00};
            else if (bus.i_stall)     m_pc = m_pc;
            else if (bus.i_halt_instr) m_mode = 3;
            else                      m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    initial begin
        i_reset = 1'b1;
        idle_in();
        m_mode = 0; m_pc = 0; m_cnt = 0;
        @(posedge i_clk); #1;
        do_reset();

        // Idle without start
        repeat (5) cyc();
        chk("idle_pc", bus.o_pc, 32'h0);

        // Continuous run: 0,4,8
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        idle_in();
        cyc(); chk("run_pc4", bus.o_pc, 32'h4); chk("run_cnt1", bus.o_cycle_count, 32'd1);
        cyc(); chk("run_pc8", bus.o_pc, 32'h8); chk("run_cnt2", bus.o_cycle_count, 32'd2);

        // Stall two cycles at 8, then advance to 12
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); cyc(); cyc();
        chk("stall_hold", bus.o_pc, 32'h8); chk("stall_cnt", bus.o_cycle_count, 32'd4);
        idle_in(); cyc(); chk("after_stall", bus.o_pc, 32'hC);

        // Branch beats stall; target alignment
        drive(0, 0, 0, 1, 1, 32'h40, 0, 0, 0); cyc(); chk("br_stall", bus.o_pc, 32'h40);
        drive(0, 0, 0, 0, 1, 32'h43, 0, 0, 0); cyc(); chk("br_align", bus.o_pc, 32'h40);

        // Jump cancels halt; stall defers halt
        drive(0, 0, 0, 0, 0, 0, 1, 32'h80, 1); cyc();
        chk("jmp_halt_pc", bus.o_pc, 32'h80); chk("jmp_halt_h", {31'b0, bus.o_halted}, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 1); cyc();
        chk("stall_halt_h", {31'b0, bus.o_halted}, 32'h0);

        // Halt at 0x10, then everything ignored
        drive(0, 0, 0, 0, 1, 32'h10, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
        chk("halt_pc", bus.o_pc, 32'h10); chk("halt_h", {31'b0, bus.o_halted}, 32'h1);
        drive(1, 1, 1, 0, 1, 32'h200, 1, 32'h300, 0); repeat (3) cyc();
        chk("halt_frozen", bus.o_pc, 32'h10);

        // Single step: pulses 10 cycles apart
        idle_in(); do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
        for (int p = 0; p < 2; p++) begin
            idle_in(); repeat (9) cyc();
            drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cyc();
            chk("step_pc", bus.o_pc, 32'(4 * (p + 1)));
        end
        idle_in(); repeat (3) cyc();
        chk("step_idle_pc", bus.o_pc, 32'h8);

        // Wrap at top of address space, then step held for 3 cycles
        drive(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); cyc();
        chk("wrap_pre", bus.o_pc, 32'hFFFF_FFFC);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cyc();
        chk("wrap_pc", bus.o_pc, 32'h0);
        repeat (3) cyc();
        chk("held_step", bus.o_pc, 32'hC);

        // Async reset between edges, with step still asserted
        do_reset();
        chk("post_rst_valid", {31'b0, bus.o_valid}, 32'h0);
        repeat (2) cyc();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (m_mode == 3 && $urandom_range(0, 7) == 0) begin
                idle_in(); do_reset();
            end else if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 24) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
